// File: rtl/ddr4_dll_code_sequencer_pkg.sv
// Shared types and default timing for the DDR4 master-DLL code sequencer.
package ddr4_dll_pkg;

  localparam int unsigned CODE_W           = 8;
  localparam int unsigned PWRDN_CYCLES_DEF = 16;
  localparam int unsigned LOCK_TIMEOUT_DEF = 4096;
  localparam int unsigned UPD_PERIOD_DEF   = 65536;
  localparam int unsigned UPD_SETTLE_DEF   = 4;
  localparam int unsigned MAX_RETRY_DEF    = 3;

  typedef enum logic [2:0] {
    StOff,
    StPwrdn,
    StWaitLock,
    StCapture,
    StTrack,
    StFault
  } dll_seq_state_t;

  function automatic int unsigned umax(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  // Bits needed to hold max_val, never less than one.
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val == 0) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/ddr4_dll_code_sequencer_if.sv
// Control/status bundle between the DDR4 controller, the master DLL and the code sequencer.
interface ddr4_dll_code_sequencer_if;
  import ddr4_dll_pkg::*;

  logic              enable;
  logic              upd_req;
  logic              upd_ack;
  logic              dll_lock;
  logic              dll_delay_diff;
  logic [CODE_W-1:0] dll_code;
  logic              dll_powerdown_n;
  logic              dll_code_update;
  logic [CODE_W-1:0] code_out;
  logic              code_valid;
  logic              ready;
  logic              fault;
  logic [1:0]        retry_cnt;

  modport master (
    output enable, upd_req, dll_lock, dll_delay_diff, dll_code,
    input  upd_ack, dll_powerdown_n, dll_code_update, code_out, code_valid, ready, fault,
           retry_cnt
  );

  modport slave (
    input  enable, upd_req, dll_lock, dll_delay_diff, dll_code,
    output upd_ack, dll_powerdown_n, dll_code_update, code_out, code_valid, ready, fault,
           retry_cnt
  );

endinterface

// File: rtl/ddr4_dll_code_sequencer_sync2.sv
// Two-flop synchroniser with synchronous active-high reset.
module dll_sync2 (
  input  logic clk,
  input  logic reset,
  input  logic d_i,
  output logic q_o
);

  logic meta_q, sync_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/ddr4_dll_code_sequencer.sv
// Master-DLL bring-up, lock supervision and delay-code refresh sequencer.
// Define DDR4_DLL_DRIFT_REFRESH_EN to refresh the code on a rising DLL drift indication.
module ddr4_dll_code_sequencer
  import ddr4_dll_pkg::*;
#(
  parameter int unsigned PWRDN_CYCLES = PWRDN_CYCLES_DEF,
  parameter int unsigned LOCK_TIMEOUT = LOCK_TIMEOUT_DEF,
  parameter int unsigned UPD_PERIOD   = UPD_PERIOD_DEF,
  parameter int unsigned UPD_SETTLE   = UPD_SETTLE_DEF,
  parameter int unsigned MAX_RETRY    = MAX_RETRY_DEF
) (
  input logic                      clk,
  input logic                      reset,
  ddr4_dll_code_sequencer_if.slave bus
);

  localparam int unsigned CNT_W = cnt_width(umax(umax(PWRDN_CYCLES, LOCK_TIMEOUT), UPD_SETTLE));
  localparam int unsigned PER_W = cnt_width(UPD_PERIOD);

  dll_seq_state_t    state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_inc;
  logic [PER_W-1:0]  per_q, per_d, per_inc;
  logic              pend_q, pend_d;
  logic [1:0]        retry_q, retry_d;
  logic              fault_q, fault_d;
  logic [CODE_W-1:0] code_q, code_d;
  logic              valid_q, valid_d, ready_q, ready_d, pdn_q, pdn_d;
  logic              cu_q, cu_d, ack_q, ack_d;
  logic              lock_s, diff_s, drift_rise, per_expire, req_any;
  logic              capture_done, lock_fail;

  dll_sync2 u_sync_lock (.clk(clk), .reset(reset), .d_i(bus.dll_lock),       .q_o(lock_s));
  dll_sync2 u_sync_diff (.clk(clk), .reset(reset), .d_i(bus.dll_delay_diff), .q_o(diff_s));

`ifdef DDR4_DLL_DRIFT_REFRESH_EN
  logic diff_prev_q;
  always_ff @(posedge clk) begin
    if (reset) diff_prev_q <= 1'b0;
    else       diff_prev_q <= diff_s;
  end
  assign drift_rise = diff_s & ~diff_prev_q;
`else
  logic unused_diff_s;
  assign unused_diff_s = diff_s;
  assign drift_rise    = 1'b0;
`endif

  assign cnt_inc    = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
  assign per_inc    = (&per_q) ? per_q : per_q + PER_W'(1);
  assign req_any    = pend_q | bus.upd_req;
  // Period is measured from the CODE_UPDATE pulse, so refresh pulses are UPD_PERIOD apart.
  assign per_expire = (UPD_PERIOD != 0) && (32'(per_q) + 32'd1 >= UPD_PERIOD);

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    pend_d       = req_any;
    retry_d      = retry_q;
    fault_d      = fault_q;
    code_d       = code_q;
    capture_done = 1'b0;
    lock_fail    = 1'b0;

    if (state_q != StOff && !bus.enable) begin
      state_d = StOff;
    end else begin
      unique case (state_q)
        StOff: begin
          if (bus.enable) begin
            state_d = StPwrdn;
            cnt_d   = '0;
            retry_d = '0;
          end
        end
        StPwrdn: begin
          if (32'(cnt_q) + 32'd1 >= PWRDN_CYCLES) begin
            state_d = StWaitLock;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        StWaitLock: begin
          if (lock_s) begin
            state_d = StCapture;
            cnt_d   = '0;
          end else if (32'(cnt_q) + 32'd1 >= LOCK_TIMEOUT) begin
            lock_fail = 1'b1;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        StCapture: begin
          if (!lock_s) begin
            lock_fail = 1'b1;
          end else if (32'(cnt_q) >= UPD_SETTLE) begin
            capture_done = 1'b1;
            state_d      = StTrack;
            code_d       = bus.dll_code;
            retry_d      = '0;
            pend_d       = 1'b0;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        StTrack: begin
          if (!lock_s) begin
            lock_fail = 1'b1;
          end else if (req_any || per_expire || drift_rise) begin
            state_d = StCapture;
            cnt_d   = '0;
          end
        end
        StFault: ;
        default: state_d = StOff;
      endcase

      if (lock_fail) begin
        cnt_d = '0;
        if (32'(retry_q) + 32'd1 < MAX_RETRY) begin
          retry_d = retry_q + 2'd1;
          state_d = StPwrdn;
        end else begin
          fault_d = 1'b1;
          state_d = StFault;
        end
      end
    end

    pdn_d   = state_d inside {StWaitLock, StCapture, StTrack};
    ready_d = (state_d == StTrack);
    cu_d    = (state_d == StCapture) && (state_q != StCapture);
    valid_d = capture_done | (valid_q & (state_d inside {StCapture, StTrack}));
    ack_d   = capture_done & req_any;
    per_d   = (cu_d || !(state_d inside {StCapture, StTrack})) ? '0 : per_inc;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StOff;
      cnt_q   <= '0;
      per_q   <= '0;
      pend_q  <= 1'b0;
      retry_q <= '0;
      fault_q <= 1'b0;
      code_q  <= '0;
      valid_q <= 1'b0;
      ready_q <= 1'b0;
      pdn_q   <= 1'b0;
      cu_q    <= 1'b0;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      per_q   <= per_d;
      pend_q  <= pend_d;
      retry_q <= retry_d;
      fault_q <= fault_d;
      code_q  <= code_d;
      valid_q <= valid_d;
      ready_q <= ready_d;
      pdn_q   <= pdn_d;
      cu_q    <= cu_d;
      ack_q   <= ack_d;
    end
  end

  assign bus.dll_powerdown_n = pdn_q;
  assign bus.dll_code_update = cu_q;
  assign bus.code_out        = code_q;
  assign bus.code_valid      = valid_q;
  assign bus.ready           = ready_q;
  assign bus.fault           = fault_q;
  assign bus.retry_cnt       = retry_q;
  assign bus.upd_ack         = ack_q;

endmodule

// File: doc/ddr4_dll_code_sequencer.md
Name: ddr4_dll_code_sequencer

Overview:
Controls the DDR4 controller's master DLL after reset. It releases the DLL from powerdown, waits for lock, and pulses CODE_UPDATE to capture the delay code. It then refreshes the code periodically or on request, and holds a registered, validated copy of the 8-bit code for the PHY lane delay lines. Lock loss or lock timeout forces a controlled powerdown and retry, up to a fixed limit, after which the block reports a fault.

Parameters:
- PWRDN_CYCLES, 16: cycles DLL_POWERDOWN_N is held low before each lock attempt (min 2).
- LOCK_TIMEOUT, 4096: cycles allowed for DLL_LOCK to assert after powerdown release.
- UPD_PERIOD, 65536: cycles between periodic code refreshes in TRACK; 0 disables periodic refresh.
- UPD_SETTLE, 4: cycles after the CODE_UPDATE pulse before DLL_CODE is sampled (min 1).
- MAX_RETRY, 3: lock attempts before entering FAULT.
- CODE_W, 8: delay code width.

Ports:
- CLK  in  1  system clock; all logic is in this domain.
- RESET  in  1  synchronous, active-high reset.
- ENABLE  in  1  level; 1 = bring up and track, 0 = orderly powerdown.
- UPD_REQ  in  1  single-cycle request for an immediate code refresh.
- UPD_ACK  out  1  single-cycle pulse when a requested refresh completes.
- DLL_LOCK  in  1  DLL lock; asynchronous, double-flop synchronised internally.
- DLL_DELAY_DIFF  in  1  DLL drift indicator; asynchronous, double-flop synchronised.
- DLL_CODE  in  CODE_W  DLL delay code; quasi-static, sampled only after settle.
- DLL_POWERDOWN_N  out  1  DLL powerdown control, active-low.
- DLL_CODE_UPDATE  out  1  one-cycle code-update strobe to the DLL.
- CODE_OUT  out  CODE_W  last captured code.
- CODE_VALID  out  1  CODE_OUT is valid and the DLL is locked.
- READY  out  1  state is TRACK.
- FAULT  out  1  sticky; set when retries are exhausted.
- RETRY_CNT  out  2  lock attempts used in the current bring-up.

Behaviour:
- Reset values: DLL_POWERDOWN_N=0, DLL_CODE_UPDATE=0, CODE_OUT=0, CODE_VALID=0, READY=0, FAULT=0, UPD_ACK=0, RETRY_CNT=0, state=OFF, synchroniser flops=0.
- All outputs are registered. The synchronised lock (lock_s) lags DLL_LOCK by 2 cycles.
- FSM states: OFF, PWRDN, WAIT_LOCK, CAPTURE, TRACK, FAULT.
  - OFF: POWERDOWN_N=0. Goes to PWRDN when ENABLE=1.
  - PWRDN: POWERDOWN_N=0 for PWRDN_CYCLES, then goes to WAIT_LOCK with POWERDOWN_N=1.
  - WAIT_LOCK: on lock_s=1, go to CAPTURE. If the counter reaches LOCK_TIMEOUT first:
    - RETRY_CNT+1 < MAX_RETRY: increment RETRY_CNT and go to PWRDN.
    - otherwise: set FAULT and go to FAULT.
  - CAPTURE: DLL_CODE_UPDATE=1 on the first cycle only. Wait UPD_SETTLE cycles, then register CODE_OUT <= DLL_CODE, set CODE_VALID=1 and go to TRACK. Pulse UPD_ACK in the same cycle if the capture was a request.
  - TRACK: READY=1. Go to CAPTURE when the period counter reaches UPD_PERIOD-1 or when an UPD_REQ is pending. The period counter clears on every capture. CODE_VALID stays 1 during refresh captures.
  - FAULT: POWERDOWN_N=0, FAULT=1. Left only by RESET, or by ENABLE=0 which goes to OFF and leaves FAULT sticky until RESET.
- Lock loss: lock_s=0 in CAPTURE or TRACK clears CODE_VALID and READY the next cycle and goes to PWRDN. RETRY_CNT counts up exactly as for a timeout.
- RETRY_CNT clears on entry to TRACK.
- ENABLE=0 in any state except OFF goes to OFF next cycle, clears CODE_VALID/READY and keeps CODE_OUT. A CAPTURE in progress is abandoned with no UPD_ACK.
- UPD_REQ outside TRACK/CAPTURE is latched as pending and served on the next TRACK entry. Multiple requests merge into one ACK. A request arriving during CAPTURE is merged into the current capture.
- Simultaneous period expiry and UPD_REQ produce one capture, with UPD_ACK.
- Counters saturate and never wrap. Counter widths come from $clog2 of the largest parameter.

Optional Feature:
- Macro: DDR4_DLL_DRIFT_REFRESH_EN.
- Defined: a rising edge of synchronised DLL_DELAY_DIFF in TRACK forces a capture on the next cycle, with no UPD_ACK. An edge arriving during CAPTURE is ignored.
- Undefined: DLL_DELAY_DIFF is unused apart from its synchroniser, which is optimised away.

Decomposition:
- Package ddr4_dll_pkg holds the state enum (dll_seq_state_t), CODE_W, and the default timing constants.
- One sub-module, dll_sync2: a 2-flop synchroniser with synchronous reset, instantiated for DLL_LOCK and DLL_DELAY_DIFF.

Test Plan:
1. RESET, ENABLE=1, DLL_LOCK rises 100 cycles after POWERDOWN_N=1, DLL_CODE=0x5A -> CODE_UPDATE pulses exactly once; CODE_OUT=0x5A with CODE_VALID=1 UPD_SETTLE+1 cycles later; READY=1.
2. DLL_LOCK never asserts, MAX_RETRY=3 -> three PWRDN/WAIT_LOCK cycles; RETRY_CNT steps 0,1,2; FAULT=1 and POWERDOWN_N=0 after the third timeout.
3. In TRACK with UPD_PERIOD=64, DLL_CODE changes to 0x33 -> a capture every 64 cycles; CODE_OUT=0x33 after the next capture; no UPD_ACK.
4. UPD_REQ in the same cycle as period expiry, then a second UPD_REQ during CAPTURE -> one CODE_UPDATE pulse and one UPD_ACK.
5. DLL_LOCK drops in TRACK -> CODE_VALID=0 within 3 cycles of the drop; relock proceeds; RETRY_CNT=1 until TRACK, then returns to 0.
6. ENABLE=0 mid-CAPTURE -> OFF next cycle, no UPD_ACK, CODE_OUT unchanged, POWERDOWN_N=0.
